// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: FIFO-side and consumer-side signals of the round-robin read arbiter; FIFO_ARB_MASK_EN adds en_mask.
interface fifo_rd_arbiter_if #(
   parameter int NUM_FIFOS = 4,
   parameter int DATA_W    = 8
);
   localparam int SRC_W = $clog2(NUM_FIFOS);
   logic [NUM_FIFOS-1:0]        empty;
   logic [NUM_FIFOS*DATA_W-1:0] fifo_dout;
   logic [NUM_FIFOS-1:0]        fifo_rd;
   logic [DATA_W-1:0]           out_data;
   logic [SRC_W-1:0]            out_src;
   logic                        out_valid;
   logic                        out_ready;
`ifdef FIFO_ARB_MASK_EN
   logic [NUM_FIFOS-1:0]        en_mask;
   modport master (input empty, fifo_dout, out_ready, en_mask, output fifo_rd, out_data, out_src, out_valid);
   modport slave (output empty, fifo_dout, out_ready, en_mask, input fifo_rd, out_data, out_src, out_valid);
`else
   modport master (input empty, fifo_dout, out_ready, output fifo_rd, out_data, out_src, out_valid);
   modport slave (output empty, fifo_dout, out_ready, input fifo_rd, out_data, out_src, out_valid);
`endif
endinterface

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst reader draining NUM_FIFOS FIFOs into one valid/ready stream; FIFO_ARB_MASK_EN adds en_mask.
module fifo_rd_arbiter #(
   parameter int NUM_FIFOS = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 2
) (
   input logic              clk,
   input logic              reset,
   fifo_rd_arbiter_if.master bus
);
   localparam int IW = $clog2(NUM_FIFOS);
   localparam int BW = $clog2(BURST_LEN + 1);
   typedef enum logic [1:0] {IDLE, READ, CAPTURE, PRESENT} state_t;
   state_t              state_q;
   logic [IW-1:0]       grant_q, last_q, grant_d, src_q;
   logic [BW-1:0]       burst_q;
   logic [DATA_W-1:0]   data_q;
   logic                valid_q;
   logic [NUM_FIFOS-1:0] req;
   logic [DATA_W-1:0]   words [NUM_FIFOS];
`ifdef FIFO_ARB_MASK_EN
   assign req = ~bus.empty & bus.en_mask;
`else
   assign req = ~bus.empty;
`endif
   always_comb
      for (int i = 0; i < NUM_FIFOS; i++) words[i] = bus.fifo_dout[i*DATA_W +: DATA_W];
   // descending scan so the nearest requester after last_q is written last and wins
   always_comb begin
      int idx;
      idx = 0;
      grant_d = last_q;
      for (int k = NUM_FIFOS; k >= 1; k--) begin
         idx = int'(last_q) + k;
         idx = (idx >= NUM_FIFOS) ? idx - NUM_FIFOS : idx;
         if (req[idx]) grant_d = IW'(idx);
      end
   end
   always_ff @(posedge clk)
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(NUM_FIFOS - 1);
         burst_q <= '0;
         data_q  <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
      end else
         case (state_q)
            IDLE:
               if (|req) begin
                  grant_q <= grant_d;
                  burst_q <= '0;
                  state_q <= READ;
               end
            READ: state_q <= CAPTURE;
            CAPTURE: begin
               data_q  <= words[grant_q];
               src_q   <= grant_q;
               valid_q <= 1'b1;
               state_q <= PRESENT;
            end
            PRESENT:
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  burst_q <= burst_q + 1'b1;
                  if ((int'(burst_q) + 1 < BURST_LEN) && req[grant_q])
                     state_q <= READ;
                  else begin
                     last_q  <= grant_q;
                     state_q <= IDLE;
                  end
               end
            default: state_q <= IDLE;
         endcase
   assign bus.fifo_rd   = (state_q == READ) ? NUM_FIFOS'(1) << grant_q : '0;
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed checks of the round-robin FIFO read arbiter against simple FIFO models.
module tb_fifo_rd_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   logic [7:0] mem  [4][32];
   int         wp   [4] = '{default: 0};
   int         rp   [4] = '{default: 0};
   logic [7:0] dout [4] = '{default: 8'h00};
   fifo_rd_arbiter_if #(.NUM_FIFOS(4), .DATA_W(8)) bus ();
   fifo_rd_arbiter #(.NUM_FIFOS(4), .DATA_W(8), .BURST_LEN(2)) dut (.clk(clk), .reset(reset), .bus(bus.master));
   always #5 clk = ~clk;
   // FIFO model: data shows up on dout the cycle after the read strobe
   always @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (bus.fifo_rd[i]) begin
            dout[i] <= mem[i][rp[i]];
            rp[i]   <= rp[i] + 1;
         end
   always_comb
      for (int i = 0; i < 4; i++) begin
         bus.empty[i] = (rp[i] == wp[i]);
         bus.fifo_dout[i*8 +: 8] = dout[i];
      end
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push(int i, logic [7:0] d);
      mem[i][wp[i]] = d;
      wp[i]++;
   endtask
   task automatic wait_valid(string tag);
      int t = 0;
      while (!bus.out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_timeout"}, 32'(t < 20), 1);
   endtask
   task automatic wait_rd(string tag);
      int t = 0;
      while (bus.fifo_rd == 4'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_timeout"}, 32'(t < 20), 1);
   endtask
   task automatic expect_word(string tag, int src, int d);
      wait_valid(tag);
      check({tag, "_src"}, 32'(bus.out_src), src);
      check({tag, "_dat"}, 32'(bus.out_data), d);
      @(negedge clk);
   endtask
   always @(negedge clk)
      if (!reset && bus.fifo_rd != 4'b0) begin
         check("rd_onehot", 32'($onehot(bus.fifo_rd)), 1);
         check("rd_nonempty", 32'(bus.fifo_rd & bus.empty), 0);
      end
   initial begin
      bus.out_ready = 1'b1;
`ifdef FIFO_ARB_MASK_EN
      bus.en_mask = 4'hF;
`endif
      for (int i = 0; i < 4; i++) push(i, 8'(8'h10 + i));
      repeat (3) begin
         @(negedge clk);
         check("rst_rd", 32'(bus.fifo_rd), 0);
         check("rst_valid", 32'(bus.out_valid), 0);
      end
      check("rst_data", 32'(bus.out_data), 0);
      check("rst_src", 32'(bus.out_src), 0);
      reset = 1'b0;
      wait_rd("first_rd");
      check("first_grant", 32'(bus.fifo_rd), 32'h1);
      for (int i = 0; i < 4; i++) expect_word("t1", i, 8'h10 + i);
      push(2, 8'hA5);
      @(negedge clk);
      check("t2_rd", 32'(bus.fifo_rd), 32'h4);
      @(negedge clk);
      check("t2_rd_off", 32'(bus.fifo_rd), 0);
      check("t2_valid_early", 32'(bus.out_valid), 0);
      @(negedge clk);
      check("t2_valid", 32'(bus.out_valid), 1);
      check("t2_dat", 32'(bus.out_data), 32'hA5);
      check("t2_src", 32'(bus.out_src), 2);
      @(negedge clk);
      check("t2_done_valid", 32'(bus.out_valid), 0);
      check("t2_no_rd", 32'(bus.fifo_rd), 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 3; j++) push(i, 8'(i * 16 + j));
      for (int i = 0; i < 4; i++) begin
         expect_word("t3a", i, i * 16);
         expect_word("t3b", i, i * 16 + 1);
      end
      for (int i = 0; i < 4; i++) expect_word("t3c", i, i * 16 + 2);
      bus.out_ready = 1'b0;
      push(0, 8'h77);
      push(1, 8'h88);
      wait_valid("t4");
      repeat (10) begin
         @(negedge clk);
         check("t4_valid", 32'(bus.out_valid), 1);
         check("t4_dat", 32'(bus.out_data), 32'h77);
         check("t4_src", 32'(bus.out_src), 0);
         check("t4_rd", 32'(bus.fifo_rd), 0);
      end
      bus.out_ready = 1'b1;
      expect_word("t4a", 0, 8'h77);
      expect_word("t4b", 1, 8'h88);
      push(2, 8'h5A);
      wait_rd("t6_rd");
      check("t6_grant", 32'(bus.fifo_rd), 32'h4);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t6_valid", 32'(bus.out_valid), 0);
      check("t6_rd", 32'(bus.fifo_rd), 0);
      reset = 1'b0;
      push(0, 8'h01);
      push(3, 8'h03);
      @(negedge clk);
      check("t6_first", 32'(bus.fifo_rd), 32'h1);
      expect_word("t6a", 0, 8'h01);
      expect_word("t6b", 3, 8'h03);
`ifdef FIFO_ARB_MASK_EN
      bus.en_mask = 4'b1110;
      push(0, 8'hE0);
      push(1, 8'hE1);
      expect_word("m1", 1, 8'hE1);
      repeat (8) begin
         @(negedge clk);
         check("m_idle", 32'(bus.out_valid), 0);
      end
      check("m_fifo0_kept", 32'(bus.empty[0]), 0);
      bus.en_mask = 4'hF;
      expect_word("m0", 0, 8'hE0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
